env_gen: RTL and testbench

ENV_GEN -- requirements
Module: env_gen

---
 rtl/env_gen.sv | 148 ++++++++++++++
 tb/tb_env_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/env_gen.sv
// ADSR envelope generator.
// Level steps once per rate_pulse tick; gate edges drive stage transitions.
// Optional macro ENV_HARD_RETRIG_EN: a retrigger (gate rise in IDLE or RELEASE)
// also clears level to 0 on the transition edge. Without it the new attack
// starts from the present level.
module env_gen #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             rate_pulse,
  input  logic             gate,
  input  logic [WIDTH-1:0] attack_step,
  input  logic [WIDTH-1:0] decay_step,
  input  logic [WIDTH-1:0] sustain_lvl,
  input  logic [WIDTH-1:0] release_step,
  output logic [WIDTH-1:0] level,
  output logic [2:0]       state,
  output logic             done
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } state_e;

  localparam logic [WIDTH-1:0] Max     = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   MaxWide = {1'b0, Max};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic             done_q, done_d;
  logic             gate_q;

  logic             rise, fall;
  logic [WIDTH:0]   att_sum;
  logic [WIDTH:0]   dec_diff;
  logic             att_hit_max;
  logic             dec_hit_sus;
  logic             rel_hit_zero;
  logic [WIDTH-1:0] retrig_level;

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;

  // Extra bit on the sum catches overflow; on the difference it is the borrow.
  assign att_sum  = {1'b0, level_q} + {1'b0, attack_step};
  assign dec_diff = {1'b0, level_q} - {1'b0, decay_step};

  // A zero step means "jump straight to the stage target on the next tick".
  assign att_hit_max  = (attack_step == '0) || (att_sum >= MaxWide);
  assign dec_hit_sus  = (decay_step == '0) || dec_diff[WIDTH] ||
                        (dec_diff[WIDTH-1:0] <= sustain_lvl);
  assign rel_hit_zero = (release_step == '0) || (level_q <= release_step);

`ifdef ENV_HARD_RETRIG_EN
  assign retrig_level = '0;
`else
  assign retrig_level = level_q;
`endif

  // Next-state, next-level and done strobe; gate edges take priority over ticks.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        level_d = '0;
        if (rise) begin
          state_d = StAttack;
          level_d = '0;
        end
      end
      StAttack: begin
        if (fall) begin
          state_d = StRelease;
        end else if (rate_pulse) begin
          if (att_hit_max) begin
            level_d = Max;
            state_d = StDecay;
          end else begin
            level_d = att_sum[WIDTH-1:0];
          end
        end
      end
      StDecay: begin
        if (fall) begin
          state_d = StRelease;
        end else if (rate_pulse) begin
          if (dec_hit_sus) begin
            level_d = sustain_lvl;
            state_d = StSustain;
          end else begin
            level_d = dec_diff[WIDTH-1:0];
          end
        end
      end
      StSustain: begin
        if (fall) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (rise) begin
          state_d = StAttack;
          level_d = retrig_level;
        end else if (rate_pulse) begin
          if (rel_hit_zero) begin
            level_d = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            level_d = level_q - release_step;
          end
        end
      end
      default: begin
        // Unreachable encodings recover to a clean idle.
        state_d = StIdle;
        level_d = '0;
      end
    endcase
  end

  // State, level, done and gate history registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      level_q <= '0;
      done_q  <= 1'b0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      done_q  <= done_d;
      gate_q  <= gate;
    end
  end

  assign level = level_q;
  assign state = state_q;
  assign done  = done_q;

endmodule

// File: tb/tb_env_gen.sv
// Directed self-checking bench for env_gen (WIDTH=8).
module tb_env_gen;

  localparam logic [2:0] SIdle = 3'd0, SAtk = 3'd1, SDec = 3'd2, SSus = 3'd3, SRel = 3'd4;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       rate_pulse = 1'b0;
  logic       gate = 1'b0;
  logic [7:0] attack_step = 8'd0;
  logic [7:0] decay_step = 8'd0;
  logic [7:0] sustain_lvl = 8'd0;
  logic [7:0] release_step = 8'd0;
  logic [7:0] level;
  logic [2:0] state;
  logic       done;

  int errors = 0;
  int checks = 0;

  env_gen #(.WIDTH(8)) dut (
    .clk(clk), .nrst(nrst), .rate_pulse(rate_pulse), .gate(gate),
    .attack_step(attack_step), .decay_step(decay_step), .sustain_lvl(sustain_lvl),
    .release_step(release_step), .level(level), .state(state), .done(done)
  );

  always #5 clk = ~clk;

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step(input logic p);
    rate_pulse = p;
    @(posedge clk);
    #1;
    rate_pulse = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (level !== 8'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (state !== SIdle) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0d want 0", done); end
    @(posedge clk); #1;
    nrst = 1'b1;
    step(1'b0);
    checks++; if (state !== SIdle) begin errors++; $display("FAIL idle_stays: got %0d want 0", state); end
  endtask

  task automatic test_attack;
    logic [7:0] exp_lvl [4] = '{8'd64, 8'd128, 8'd192, 8'd255};
    attack_step = 8'd64;
    gate = 1'b1;
    step(1'b0);
    checks++; if (state !== SAtk) begin errors++; $display("FAIL atk_enter: got %0d want 1", state); end
    checks++; if (level !== 8'd0) begin errors++; $display("FAIL atk_enter_lvl: got %0d want 0", level); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      checks++;
      if (level !== exp_lvl[i]) begin
        errors++; $display("FAIL atk_lvl%0d: got %0d want %0d", i, level, exp_lvl[i]);
      end
      checks++;
      if (state !== ((i == 3) ? SDec : SAtk)) begin
        errors++; $display("FAIL atk_state%0d: got %0d want %0d", i, state, (i == 3) ? SDec : SAtk);
      end
      for (int k = 0; k < 3; k++) step(1'b0);
    end
    checks++; if (level !== 8'd255) begin errors++; $display("FAIL atk_hold: got %0d want 255", level); end
  endtask

  task automatic test_decay;
    logic [7:0] exp_lvl [6] = '{8'd205, 8'd155, 8'd105, 8'd100, 8'd100, 8'd100};
    decay_step = 8'd50;
    sustain_lvl = 8'd100;
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      checks++;
      if (level !== exp_lvl[i]) begin
        errors++; $display("FAIL dec_lvl%0d: got %0d want %0d", i, level, exp_lvl[i]);
      end
      checks++;
      if (state !== ((i >= 3) ? SSus : SDec)) begin
        errors++; $display("FAIL dec_state%0d: got %0d want %0d", i, state, (i >= 3) ? SSus : SDec);
      end
      step(1'b0);
    end
  endtask

  task automatic test_release;
    logic [7:0] exp_lvl [3] = '{8'd60, 8'd20, 8'd0};
    release_step = 8'd40;
    gate = 1'b0;
    step(1'b0);
    checks++; if (state !== SRel) begin errors++; $display("FAIL rel_enter: got %0d want 4", state); end
    checks++; if (level !== 8'd100) begin errors++; $display("FAIL rel_enter_lvl: got %0d want 100", level); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      checks++;
      if (level !== exp_lvl[i]) begin
        errors++; $display("FAIL rel_lvl%0d: got %0d want %0d", i, level, exp_lvl[i]);
      end
      checks++;
      if (done !== (i == 2)) begin
        errors++; $display("FAIL rel_done%0d: got %0d want %0d", i, done, i == 2);
      end
      checks++;
      if (state !== ((i == 2) ? SIdle : SRel)) begin
        errors++; $display("FAIL rel_state%0d: got %0d want %0d", i, state, (i == 2) ? SIdle : SRel);
      end
    end
    step(1'b0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %0d want 0", done); end
  endtask

  task automatic test_retrigger;
    logic [7:0] exp_retrig, exp_after;
`ifdef ENV_HARD_RETRIG_EN
    exp_retrig = 8'd0;
    exp_after  = 8'd64;
`else
    exp_retrig = 8'd60;
    exp_after  = 8'd124;
`endif
    gate = 1'b1; attack_step = 8'd0; decay_step = 8'd0; sustain_lvl = 8'd100;
    step(1'b0);
    step(1'b1);
    checks++; if (level !== 8'd255) begin errors++; $display("FAIL zero_atk: got %0d want 255", level); end
    step(1'b1);
    checks++; if (level !== 8'd100) begin errors++; $display("FAIL zero_dec: got %0d want 100", level); end
    checks++; if (state !== SSus) begin errors++; $display("FAIL zero_dec_st: got %0d want 3", state); end
    gate = 1'b0;
    step(1'b0);
    step(1'b1);
    checks++; if (level !== 8'd60) begin errors++; $display("FAIL pre_retrig: got %0d want 60", level); end
    gate = 1'b1;
    step(1'b0);
    checks++; if (state !== SAtk) begin errors++; $display("FAIL retrig_state: got %0d want 1", state); end
    checks++; if (level !== exp_retrig) begin errors++; $display("FAIL retrig_lvl: got %0d want %0d", level, exp_retrig); end
    attack_step = 8'd64;
    step(1'b1);
    checks++; if (level !== exp_after) begin errors++; $display("FAIL legato: got %0d want %0d", level, exp_after); end
    // Fall coincident with a tick: transition only, no step.
    gate = 1'b0;
    step(1'b1);
    checks++; if (state !== SRel) begin errors++; $display("FAIL fall_tick_st: got %0d want 4", state); end
    checks++; if (level !== exp_after) begin errors++; $display("FAIL fall_tick_lvl: got %0d want %0d", level, exp_after); end
    release_step = 8'd0;
    step(1'b1);
    checks++; if (level !== 8'd0) begin errors++; $display("FAIL zero_rel: got %0d want 0", level); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_rel_done: got %0d want 1", done); end
  endtask

  task automatic test_coincident;
    attack_step = 8'd0;
    gate = 1'b1;
    step(1'b1);
    checks++; if (state !== SAtk) begin errors++; $display("FAIL coinc_state: got %0d want 1", state); end
    checks++; if (level !== 8'd0) begin errors++; $display("FAIL coinc_lvl: got %0d want 0", level); end
    step(1'b1);
    checks++; if (level !== 8'd255) begin errors++; $display("FAIL coinc_next: got %0d want 255", level); end
    checks++; if (state !== SDec) begin errors++; $display("FAIL coinc_dec: got %0d want 2", state); end
    // Sustain at full scale leaves DECAY on the first tick.
    sustain_lvl = 8'd255; decay_step = 8'd10;
    step(1'b1);
    checks++; if (state !== SSus) begin errors++; $display("FAIL sus_max_st: got %0d want 3", state); end
    checks++; if (level !== 8'd255) begin errors++; $display("FAIL sus_max_lvl: got %0d want 255", level); end
  endtask

  task automatic test_reset_mid;
    gate = 1'b0;
    step(1'b0);
    release_step = 8'd0;
    step(1'b1);
    step(1'b0);
    attack_step = 8'd64;
    gate = 1'b1;
    step(1'b0);
    step(1'b1);
    step(1'b1);
    checks++; if (level !== 8'd128) begin errors++; $display("FAIL mid_pre: got %0d want 128", level); end
    #3;
    nrst = 1'b0;
    #1;
    checks++; if (level !== 8'd0) begin errors++; $display("FAIL async_lvl: got %0d want 0", level); end
    checks++; if (state !== SIdle) begin errors++; $display("FAIL async_state: got %0d want 0", state); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL async_done: got %0d want 0", done); end
    @(posedge clk); #3;
    nrst = 1'b1;
    @(posedge clk); #1;
    checks++; if (state !== SAtk) begin errors++; $display("FAIL post_rst_atk: got %0d want 1", state); end
    checks++; if (level !== 8'd0) begin errors++; $display("FAIL post_rst_lvl: got %0d want 0", level); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL post_rst_done: got %0d want 0", done); end
  endtask

  initial begin
    test_reset;
    test_attack;
    test_decay;
    test_release;
    test_retrigger;
    test_coincident;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
